// File: rtl/frame_field_relay.sv
// Receive-to-transmit relay: bit-reverse and field-extract each received frame,
// buffer the fields in a small FIFO and hand them to a UART transmitter one at a time.
module frame_field_relay #(
  parameter int FRAME_WIDTH = 13,
  parameter int FIELD_LSB   = 4,
  parameter int FIELD_WIDTH = 8,
  parameter int REVERSE     = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rx_valid,
  input  logic [FRAME_WIDTH-1:0]            rx_frame,
  input  logic                              rx_error,
  input  logic                              tx_busy,
  input  logic                              clr_status,
  output logic                              tx_start,
  output logic [FIELD_WIDTH-1:0]            tx_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overflow,
  output logic [15:0]                       drop_count,
  output logic [15:0]                       err_count
);

  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_ARM   = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [FRAME_WIDTH-1:0] rev_frame;
  logic [FIELD_WIDTH-1:0] field;
  logic                   unused_rev_parity;

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_WIDTH; gi++) begin : g_rev
      if (REVERSE != 0) begin : g_flip
        assign rev_frame[gi] = rx_frame[FRAME_WIDTH-1-gi];
      end else begin : g_pass
        assign rev_frame[gi] = rx_frame[gi];
      end
    end
  endgenerate

  assign field = rev_frame[FIELD_LSB +: FIELD_WIDTH];
  // Bits outside the field are intentionally discarded.
  assign unused_rev_parity = ^rev_frame;

  logic [FIELD_WIDTH-1:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [LEVEL_W-1:0]     level_reg;
  logic [LEVEL_W-1:0]     level_next;
  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic                   tx_start_reg;
  logic [FIELD_WIDTH-1:0] tx_data_reg;
  logic                   overflow_reg;
  logic [15:0]            drop_count_reg;
  logic [15:0]            err_count_reg;

  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic err_hit;

  assign push_req = rx_valid & ~rx_error;
  assign err_hit  = rx_valid & rx_error;
  assign full     = (level_reg == FULL_LEVEL);
  // A pop in the same cycle frees the slot, so a push on a full FIFO is still taken.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (level_reg != '0 && !tx_busy) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: state_next = ST_ARM;
      // The transmitter raises busy a cycle late, so ARM ignores it.
      ST_ARM:   state_next = ST_WAIT;
      ST_WAIT: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LEVEL_W'(1);
      2'b01:   level_next = level_reg - LEVEL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= field;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      state_reg    <= ST_IDLE;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      level_reg    <= level_next;
      state_reg    <= state_next;
      tx_start_reg <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        tx_data_reg <= mem_reg[rd_ptr_reg];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      err_count_reg  <= '0;
    end else if (clr_status) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
      err_count_reg  <= '0;
    end else begin
      if (drop) overflow_reg <= 1'b1;
      if (drop && drop_count_reg != 16'hFFFF) drop_count_reg <= drop_count_reg + 16'd1;
      if (err_hit && err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign tx_start   = tx_start_reg;
  assign tx_data    = tx_data_reg;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_frame_field_relay.sv
// Scoreboard bench for frame_field_relay: a reversing instance (defaults) and a
// straight-through instance share stimulus; a simple UART model drives tx_busy.
module tb_frame_field_relay;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [12:0] rx_frame = '0;
  logic        rx_error = 1'b0;
  logic        clr_status = 1'b0;
  logic        force_busy = 1'b0;
  logic        uart_busy = 1'b0;
  logic        tx_busy;

  logic        tx_start_a, tx_start_b;
  logic [7:0]  tx_data_a, tx_data_b;
  logic [2:0]  level_a, level_b;
  logic        overflow_a, overflow_b;
  logic [15:0] drop_a, drop_b, err_a, err_b;

  assign tx_busy = force_busy | uart_busy;

  always #5 clk = ~clk;

  frame_field_relay dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_frame(rx_frame), .rx_error(rx_error),
    .tx_busy(tx_busy), .clr_status(clr_status), .tx_start(tx_start_a), .tx_data(tx_data_a),
    .fifo_level(level_a), .overflow(overflow_a), .drop_count(drop_a), .err_count(err_a)
  );

  frame_field_relay #(.REVERSE(0), .FIELD_LSB(0), .FIELD_WIDTH(8)) dut_fwd (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_frame(rx_frame), .rx_error(rx_error),
    .tx_busy(tx_busy), .clr_status(clr_status), .tx_start(tx_start_b), .tx_data(tx_data_b),
    .fifo_level(level_b), .overflow(overflow_b), .drop_count(drop_b), .err_count(err_b)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  int tx_seen = 0;
  int last_tx_cyc = 0;
  int uart_cnt = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] model_rev(input logic [12:0] f);
    logic [12:0] r;
    for (int i = 0; i < 13; i++) r[i] = f[12-i];
    return r[11:4];
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter model: busy from the cycle after tx_start for six cycles.
  initial forever begin
    @(negedge clk);
    if (tx_start_a) uart_cnt = 6;
    else if (uart_cnt > 0) uart_cnt--;
    uart_busy = (uart_cnt > 0);
  end

  initial forever begin
    @(negedge clk);
    if (tx_start_a) begin
      tx_seen++;
      last_tx_cyc = cyc;
      if (q_a.size() == 0) check("unexpected_tx_a", {31'd0, tx_start_a}, 32'd0);
      else check("tx_data_a", {24'd0, tx_data_a}, {24'd0, q_a.pop_front()});
      $display("tx_a cycle %0d data %02h", cyc, tx_data_a);
    end
    if (tx_start_b) begin
      if (q_b.size() == 0) check("unexpected_tx_b", {31'd0, tx_start_b}, 32'd0);
      else check("tx_data_b", {24'd0, tx_data_b}, {24'd0, q_b.pop_front()});
    end
  end

  // Entered and left at a negative edge; drives one rx_valid cycle.
  task automatic send(input logic [12:0] f, input bit err, input bit acc,
                      input logic [7:0] ea, input logic [7:0] eb);
    rx_valid = 1'b1;
    rx_frame = f;
    rx_error = err;
    if (!err && acc) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic send_rand(input bit acc);
    logic [12:0] f;
    f = 13'($urandom);
    send(f, 1'b0, acc, model_rev(f), f[7:0]);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || level_a != 0 || uart_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", {31'd0, n < 400}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int rx_cyc;
    int seen;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx_cyc;
    int seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx_start", {31'd0, tx_start_a}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data_a}, 32'd0);
    check("rst_level", {29'd0, level_a}, 32'd0);
    check("rst_overflow", {31'd0, overflow_a}, 32'd0);
    check("rst_drop", {16'd0, drop_a}, 32'd0);
    check("rst_err", {16'd0, err_a}, 32'd0);

    // Single frame, end-to-end latency.
    rx_cyc = cyc;
    send(13'h0100, 1'b0, 1'b1, 8'h01, 8'h00);
    check("push_level", {29'd0, level_a}, 32'd1);
    drain();
    check("latency", last_tx_cyc - rx_cyc, 32'd2);
    check("level_empty", {29'd0, level_a}, 32'd0);

    // Back-to-back frames, reversal boundary, non-reversed instance.
    send(13'h0002, 1'b0, 1'b1, 8'h80, 8'h02);
    send(13'h0001, 1'b0, 1'b1, 8'h00, 8'h01);
    send(13'h01A5, 1'b0, 1'b1, 8'h4B, 8'hA5);
    drain();

    // Overflow while the transmitter is held busy.
    force_busy = 1'b1;
    seen = tx_seen;
    for (int i = 0; i < 6; i++) send_rand(i < 4);
    check("full_level", {29'd0, level_a}, 32'd4);
    check("overflow_set", {31'd0, overflow_a}, 32'd1);
    check("drop_count", {16'd0, drop_a}, 32'd2);
    check("no_tx_when_busy", tx_seen, seen);

    // Release busy together with a push: pop and push coincide on a full FIFO.
    force_busy = 1'b0;
    send_rand(1'b1);
    check("full_pop_push_level", {29'd0, level_a}, 32'd4);
    check("full_pop_push_drop", {16'd0, drop_a}, 32'd2);
    drain();

    // Errored frames.
    for (int i = 0; i < 3; i++) send(13'h1FFF, 1'b1, 1'b0, 8'h00, 8'h00);
    check("err_count", {16'd0, err_a}, 32'd3);
    check("err_no_push", {29'd0, level_a}, 32'd0);
    check("overflow_sticky", {31'd0, overflow_a}, 32'd1);
    clr_status = 1'b1;
    send(13'h1FFF, 1'b1, 1'b0, 8'h00, 8'h00);
    clr_status = 1'b0;
    check("clr_err", {16'd0, err_a}, 32'd0);
    check("clr_overflow", {31'd0, overflow_a}, 32'd0);
    check("clr_drop", {16'd0, drop_a}, 32'd0);

    // Spaced random traffic through the transmitter model.
    for (int i = 0; i < 5; i++) begin
      send_rand(1'b1);
      repeat (11) @(negedge clk);
    end
    drain();

    // Reset while waiting on the transmitter with two fields still queued.
    send_rand(1'b1);
    send_rand(1'b1);
    send_rand(1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_level", {29'd0, level_a}, 32'd2);
    rst = 1'b1;
    q_a.delete();
    q_b.delete();
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_level", {29'd0, level_a}, 32'd0);
    check("post_rst_tx_start", {31'd0, tx_start_a}, 32'd0);
    seen = tx_seen;
    repeat (30) @(negedge clk);
    check("post_rst_no_tx", tx_seen, seen);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
